// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and decode-class encodings used by
// the ID/EX stage and its ALU control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ClsLdSt   = 2'b00,
    ClsBranch = 2'b01,
    ClsRType  = 2'b10,
    ClsIType  = 2'b11
  } alu_class_e;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps decode class and funct fields to a 4-bit ALUOp,
// flagging unsupported combinations as Illegal (which then default to ADD).
module alu_control
  import alu_pkg::*;
(
  input  logic [1:0] AluOpClass,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  output logic [3:0] ALUOp,
  output logic       Illegal
);

  always_comb begin
    ALUOp   = ALU_ADD;
    Illegal = 1'b0;
    case (AluOpClass)
      ClsLdSt:   ALUOp = ALU_ADD;
      ClsBranch: ALUOp = ALU_SUB;
      ClsRType: begin
        case (Funct3)
          3'b000:  ALUOp = Funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  ALUOp = ALU_AND;
          3'b110:  ALUOp = ALU_OR;
          default: Illegal = 1'b1;
        endcase
      end
      ClsIType: begin
        // Bit 30 is part of the immediate here, so it never selects SUB.
        case (Funct3)
          3'b000:  ALUOp = ALU_ADD;
          3'b111:  ALUOp = ALU_AND;
          3'b110:  ALUOp = ALU_OR;
          default: Illegal = 1'b1;
        endcase
      end
      default: Illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_feed.sv
// ID/EX pipeline register feeding the ALU: one-entry valid/ready stage with
// capture-time ALUOp decode, EX/MEM and MEM/WB forwarding, and a stall counter.
module id_ex_alu_feed
  import alu_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [1:0]             AluOpClass,
  input  logic [2:0]             Funct3,
  input  logic                   Funct7b5,
  input  logic [XLEN-1:0]        RegData1,
  input  logic [XLEN-1:0]        RegData2,
  input  logic [XLEN-1:0]        Imm,
  input  logic                   AluSrc,
  input  logic [4:0]             Rs1,
  input  logic [4:0]             Rs2,
  input  logic [4:0]             Rd,
  input  logic                   RegWrite,
  input  logic                   Flush,
  input  logic                   ExMemRegWrite,
  input  logic                   MemWbRegWrite,
  input  logic [4:0]             ExMemRd,
  input  logic [4:0]             MemWbRd,
  input  logic [XLEN-1:0]        ExMemResult,
  input  logic [XLEN-1:0]        MemWbResult,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [XLEN-1:0]        Number1,
  output logic [XLEN-1:0]        Number2,
  output logic [3:0]             ALUOp,
  output logic [4:0]             RdOut,
  output logic                   RegWriteOut,
  output logic                   Illegal,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic                   r_valid;
  logic [3:0]             r_aluop;
  logic                   r_illegal;
  logic [XLEN-1:0]        r_rd1;
  logic [XLEN-1:0]        r_rd2;
  logic [XLEN-1:0]        r_imm;
  logic                   r_alusrc;
  logic [4:0]             r_rs1;
  logic [4:0]             r_rs2;
  logic [4:0]             r_rd;
  logic                   r_regwrite;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic            w_capture;
  logic [3:0]      w_aluop;
  logic            w_illegal;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  alu_control u_alu_control (
    .AluOpClass (AluOpClass),
    .Funct3     (Funct3),
    .Funct7b5   (Funct7b5),
    .ALUOp      (w_aluop),
    .Illegal    (w_illegal)
  );

  assign InReady   = !r_valid || OutReady;
  assign w_capture = InValid && InReady;

  // Flush wins over both capture and hold; a flushed offer never loads data.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid    <= 1'b0;
      r_aluop    <= 4'b0000;
      r_illegal  <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_alusrc   <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
    end else if (Flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_aluop    <= w_aluop;
      r_illegal  <= w_illegal;
      r_rd1      <= RegData1;
      r_rd2      <= RegData2;
      r_imm      <= Imm;
      r_alusrc   <= AluSrc;
      r_rs1      <= Rs1;
      r_rs2      <= Rs2;
      r_rd       <= Rd;
      r_regwrite <= RegWrite;
    end else if (r_valid && OutReady) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !OutReady && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  // EX/MEM is the younger result, so it takes precedence over MEM/WB.
  always_comb begin
    w_fwd1 = r_rd1;
    if (ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == r_rs1)) begin
      w_fwd1 = ExMemResult;
    end else if (MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == r_rs1)) begin
      w_fwd1 = MemWbResult;
    end
    w_fwd2 = r_rd2;
    if (ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == r_rs2)) begin
      w_fwd2 = ExMemResult;
    end else if (MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == r_rs2)) begin
      w_fwd2 = MemWbResult;
    end
  end

  assign Number1     = w_fwd1;
  assign Number2     = r_alusrc ? r_imm : w_fwd2;
  assign OutValid    = r_valid;
  assign ALUOp       = r_aluop;
  assign Illegal     = r_illegal;
  assign RdOut       = r_rd;
  assign RegWriteOut = r_regwrite;
  assign StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_alu_feed.sv
// Directed scoreboard bench for id_ex_alu_feed: decode, forwarding, back-pressure,
// flush, stall saturation and asynchronous reset.
module tb_id_ex_alu_feed;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        InValid, InReady;
  logic [1:0]  AluOpClass;
  logic [2:0]  Funct3;
  logic        Funct7b5;
  logic [63:0] RegData1, RegData2, Imm;
  logic        AluSrc;
  logic [4:0]  Rs1, Rs2, Rd;
  logic        RegWrite, Flush;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemRd, MemWbRd;
  logic [63:0] ExMemResult, MemWbResult;
  logic        OutValid, OutReady;
  logic [63:0] Number1, Number2;
  logic [3:0]  ALUOp;
  logic [4:0]  RdOut;
  logic        RegWriteOut, Illegal;
  logic [15:0] StallCount;

  typedef struct {
    logic [3:0]  aluop;
    logic        ill;
    logic [63:0] n1;
    logic [63:0] n2;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 Clock = ~Clock;

  id_ex_alu_feed #(
    .XLEN        (64),
    .STALL_CNT_W (16)
  ) dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .InValid       (InValid),
    .InReady       (InReady),
    .AluOpClass    (AluOpClass),
    .Funct3        (Funct3),
    .Funct7b5      (Funct7b5),
    .RegData1      (RegData1),
    .RegData2      (RegData2),
    .Imm           (Imm),
    .AluSrc        (AluSrc),
    .Rs1           (Rs1),
    .Rs2           (Rs2),
    .Rd            (Rd),
    .RegWrite      (RegWrite),
    .Flush         (Flush),
    .ExMemRegWrite (ExMemRegWrite),
    .MemWbRegWrite (MemWbRegWrite),
    .ExMemRd       (ExMemRd),
    .MemWbRd       (MemWbRd),
    .ExMemResult   (ExMemResult),
    .MemWbResult   (MemWbResult),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .Number1       (Number1),
    .Number2       (Number2),
    .ALUOp         (ALUOp),
    .RdOut         (RdOut),
    .RegWriteOut   (RegWriteOut),
    .Illegal       (Illegal),
    .StallCount    (StallCount)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one offer for a cycle; optionally record what the stage must present.
  task automatic offer(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                       input logic [63:0] rd1, input logic [63:0] rd2,
                       input logic [63:0] imm, input logic src,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw,
                       input logic [3:0] exp_op, input logic exp_ill, input bit push);
    AluOpClass = cls; Funct3 = f3; Funct7b5 = f7;
    RegData1 = rd1; RegData2 = rd2; Imm = imm; AluSrc = src;
    Rs1 = rs1; Rs2 = rs2; Rd = rd; RegWrite = rw;
    InValid = 1'b1;
    if (push) sb.push_back('{aluop: exp_op, ill: exp_ill, n1: rd1,
                             n2: (src ? imm : rd2), rd: rd, rw: rw});
    tick();
    InValid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 64'(OutValid), 64'd1);
    checks++;
    assert (sb.size() > 0)
    else begin
      failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".aluop"}, 64'(ALUOp), 64'(e.aluop));
      chk({tag, ".illegal"}, 64'(Illegal), 64'(e.ill));
      chk({tag, ".n1"}, Number1, e.n1);
      chk({tag, ".n2"}, Number2, e.n2);
      chk({tag, ".rd"}, 64'(RdOut), 64'(e.rd));
      chk({tag, ".rw"}, 64'(RegWriteOut), 64'(e.rw));
    end
  endtask

  initial begin
    Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b1; Flush = 1'b0;
    AluOpClass = 2'b00; Funct3 = 3'b000; Funct7b5 = 1'b0;
    RegData1 = '0; RegData2 = '0; Imm = '0; AluSrc = 1'b0;
    Rs1 = '0; Rs2 = '0; Rd = '0; RegWrite = 1'b0;
    ExMemRegWrite = 1'b0; MemWbRegWrite = 1'b0; ExMemRd = '0; MemWbRd = '0;
    ExMemResult = '0; MemWbResult = '0;
    #12 Reset_n = 1'b1;
    tick();

    chk("rst.valid", 64'(OutValid), 64'd0);
    chk("rst.inready", 64'(InReady), 64'd1);
    chk("rst.stall", 64'(StallCount), 64'd0);
    chk("rst.n1", Number1, 64'd0);
    chk("rst.aluop", 64'(ALUOp), 64'd0);

    // R-type SUB
    offer(2'b10, 3'b000, 1'b1, 64'd10, 64'd3, 64'd0, 1'b0, 5'd1, 5'd2, 5'd7, 1'b1,
          4'b0110, 1'b0, 1'b1);
    pop_check("sub");

    // Forwarding on held Rs1=Rs2=5
    offer(2'b10, 3'b000, 1'b0, 64'h11, 64'h22, 64'd0, 1'b0, 5'd5, 5'd5, 5'd8, 1'b1,
          4'b0010, 1'b0, 1'b1);
    ExMemRegWrite = 1'b1; ExMemRd = 5'd5; ExMemResult = 64'hAA;
    MemWbRegWrite = 1'b1; MemWbRd = 5'd5; MemWbResult = 64'hBB;
    #1;
    chk("fwd.exmem.n1", Number1, 64'hAA);
    chk("fwd.exmem.n2", Number2, 64'hAA);
    ExMemRegWrite = 1'b0;
    #1;
    chk("fwd.memwb.n1", Number1, 64'hBB);
    chk("fwd.memwb.n2", Number2, 64'hBB);
    MemWbRegWrite = 1'b0;
    #1;
    pop_check("fwd.none");

    offer(2'b10, 3'b000, 1'b0, 64'h33, 64'h44, 64'd0, 1'b0, 5'd0, 5'd3, 5'd9, 1'b1,
          4'b0010, 1'b0, 1'b1);
    ExMemRegWrite = 1'b1; ExMemRd = 5'd0; ExMemResult = 64'hAA;
    MemWbRegWrite = 1'b1; MemWbRd = 5'd0; MemWbResult = 64'hBB;
    #1;
    chk("fwd.x0.n1", Number1, 64'h33);
    ExMemRegWrite = 1'b0; MemWbRegWrite = 1'b0;
    #1;
    pop_check("fwd.x0");

    // Back-pressure with a competing offer that must not be taken
    offer(2'b11, 3'b000, 1'b0, 64'd1, 64'd2, 64'd5, 1'b1, 5'd4, 5'd6, 5'd9, 1'b0,
          4'b0010, 1'b0, 1'b1);
    OutReady = 1'b0;
    InValid = 1'b1; AluOpClass = 2'b01; RegData1 = 64'd999; Rd = 5'd3;
    repeat (5) tick();
    chk("bp.inready", 64'(InReady), 64'd0);
    chk("bp.aluop", 64'(ALUOp), 64'b0010);
    chk("bp.n1", Number1, 64'd1);
    chk("bp.rd", 64'(RdOut), 64'd9);
    chk("bp.stall", 64'(StallCount), 64'd5);
    InValid = 1'b0; OutReady = 1'b1;
    pop_check("bp");

    // Flush wins over a simultaneous capture
    Flush = 1'b1;
    offer(2'b10, 3'b111, 1'b0, 64'd7, 64'd7, 64'd0, 1'b0, 5'd1, 5'd1, 5'd12, 1'b1,
          4'b0000, 1'b0, 1'b0);
    Flush = 1'b0;
    chk("flush.valid", 64'(OutValid), 64'd0);
    tick();
    chk("flush.lost", 64'(OutValid), 64'd0);

    // Back-to-back decode sweep
    offer(2'b11, 3'b111, 1'b1, 64'h0F, 64'h3C, 64'd0, 1'b0, 5'd1, 5'd2, 5'd10, 1'b1,
          4'b0000, 1'b0, 1'b1);
    pop_check("dec.iand");
    offer(2'b10, 3'b110, 1'b0, 64'h0F, 64'h30, 64'd0, 1'b0, 5'd1, 5'd2, 5'd11, 1'b1,
          4'b0001, 1'b0, 1'b1);
    pop_check("dec.ror");
    offer(2'b10, 3'b001, 1'b0, 64'd5, 64'd6, 64'd0, 1'b0, 5'd1, 5'd2, 5'd13, 1'b1,
          4'b0010, 1'b1, 1'b1);
    pop_check("dec.illegal");
    offer(2'b00, 3'b011, 1'b1, 64'd100, 64'd0, 64'd8, 1'b1, 5'd1, 5'd2, 5'd14, 1'b0,
          4'b0010, 1'b0, 1'b1);
    pop_check("dec.ldst");
    offer(2'b01, 3'b001, 1'b0, 64'd9, 64'd4, 64'd0, 1'b0, 5'd1, 5'd2, 5'd15, 1'b0,
          4'b0110, 1'b0, 1'b1);
    pop_check("dec.branch");
    offer(2'b11, 3'b000, 1'b1, 64'd20, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1,
          5'd1, 5'd2, 5'd16, 1'b1, 4'b0010, 1'b0, 1'b1);
    pop_check("dec.immneg");

    // Stall counter saturation, then async reset mid-cycle
    offer(2'b01, 3'b000, 1'b0, 64'd7, 64'd2, 64'd0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1,
          4'b0110, 1'b0, 1'b1);
    pop_check("sat.entry");
    OutReady = 1'b0;
    repeat (65539) tick();
    chk("sat.stall", 64'(StallCount), 64'hFFFF);
    chk("sat.aluop", 64'(ALUOp), 64'b0110);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst.valid", 64'(OutValid), 64'd0);
    chk("arst.aluop", 64'(ALUOp), 64'd0);
    chk("arst.stall", 64'(StallCount), 64'd0);
    chk("arst.n1", Number1, 64'd0);
    chk("arst.rd", 64'(RdOut), 64'd0);
    Reset_n = 1'b1;
    OutReady = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
